// File: rtl/pcpu_pipe_pkg.sv
// Shared definitions for the PCPU pipeline-stage registers: occupancy encoding,
// control-bit positions and default payload widths per stage boundary.
package pcpu_pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } occ_state_t;

    localparam int CTRL_WMEM  = 0;
    localparam int CTRL_WREG  = 1;
    localparam int CTRL_RMEM  = 2;
    localparam int CTRL_M2REG = 3;

    // pc + inst + alu_out + store data + dest reg
    localparam int EXMEM_DATA_W = 32 + 32 + 32 + 32 + 5;

endpackage

// File: rtl/pipe_skid_slot.sv
// One valid+ctrl+data holding register; 1-cycle load, clear wins over load.
// Clear drops valid and ctrl but keeps data; only reset zeroes the payload.
module pipe_skid_slot #(
    parameter int CTRL_W = 4,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              load,
    input  logic [CTRL_W-1:0] ld_ctrl,
    input  logic [DATA_W-1:0] ld_data,
    output logic              vld,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data
);

    always_ff @(posedge clk) begin
        if (rst) begin
            vld  <= 1'b0;
            ctrl <= '0;
            data <= '0;
        end else if (clr) begin
            vld  <= 1'b0;
            ctrl <= '0;
        end else if (load) begin
            vld  <= 1'b1;
            ctrl <= ld_ctrl;
            data <= ld_data;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline-stage register: 1-cycle latency, valid/ready on both sides,
// optional two-entry skid (registered in_ready) and flush that squashes held entries.
module pipe_stage_reg
    import pcpu_pipe_pkg::*;
#(
    parameter int DATA_W = 128,
    parameter int CTRL_W = 4,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              take;
    logic              consume;
    logic              main_load;
    logic              main_clr;
    logic [CTRL_W-1:0] main_ld_ctrl;
    logic [DATA_W-1:0] main_ld_data;

    // An input offered during a flush is discarded even if in_ready is high.
    assign take    = in_valid & in_ready & ~flush;
    assign consume = out_valid & out_ready;

    pipe_skid_slot #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W)
    ) u_main (
        .clk     (clk),
        .rst     (rst),
        .clr     (main_clr),
        .load    (main_load),
        .ld_ctrl (main_ld_ctrl),
        .ld_data (main_ld_data),
        .vld     (out_valid),
        .ctrl    (out_ctrl),
        .data    (out_data)
    );

    generate
        if (SKID != 0) begin : g_skid
            occ_state_t        state;
            occ_state_t        state_nxt;
            logic              rdy_q;
            logic              skid_load;
            logic              skid_clr;
            logic              main_from_skid;
            logic              skid_vld;
            logic [CTRL_W-1:0] skid_ctrl;
            logic [DATA_W-1:0] skid_data;

            always_comb begin
                state_nxt      = state;
                main_load      = 1'b0;
                main_clr       = 1'b0;
                skid_load      = 1'b0;
                skid_clr       = 1'b0;
                main_from_skid = 1'b0;
                if (flush) begin
                    main_clr  = 1'b1;
                    skid_clr  = 1'b1;
                    state_nxt = ST_EMPTY;
                end else begin
                    case (state)
                        ST_EMPTY: begin
                            if (take) begin
                                main_load = 1'b1;
                                state_nxt = ST_ONE;
                            end
                        end
                        ST_ONE: begin
                            if (take && !consume) begin
                                skid_load = 1'b1;
                                state_nxt = ST_TWO;
                            end else if (take) begin
                                main_load = 1'b1;
                            end else if (consume) begin
                                main_clr  = 1'b1;
                                state_nxt = ST_EMPTY;
                            end
                        end
                        ST_TWO: begin
                            if (consume) begin
                                main_load      = 1'b1;
                                main_from_skid = 1'b1;
                                skid_clr       = 1'b1;
                                state_nxt      = ST_ONE;
                            end
                        end
                        default: begin
                            main_clr  = 1'b1;
                            skid_clr  = 1'b1;
                            state_nxt = ST_EMPTY;
                        end
                    endcase
                end
            end

            // in_ready is a flop so out_ready never reaches it combinationally.
            always_ff @(posedge clk) begin
                if (rst) begin
                    state <= ST_EMPTY;
                    rdy_q <= 1'b0;
                end else begin
                    state <= state_nxt;
                    rdy_q <= (state_nxt != ST_TWO);
                end
            end

            pipe_skid_slot #(
                .CTRL_W (CTRL_W),
                .DATA_W (DATA_W)
            ) u_skid (
                .clk     (clk),
                .rst     (rst),
                .clr     (skid_clr),
                .load    (skid_load),
                .ld_ctrl (in_ctrl),
                .ld_data (in_data),
                .vld     (skid_vld),
                .ctrl    (skid_ctrl),
                .data    (skid_data)
            );

            assign main_ld_ctrl = main_from_skid ? skid_ctrl : in_ctrl;
            assign main_ld_data = main_from_skid ? skid_data : in_data;
            assign in_ready     = rdy_q;
            assign occupancy    = {state[1], state[0] & ~skid_vld | state[0]};
        end else begin : g_single
            assign in_ready     = ~out_valid | out_ready;
            assign main_load    = take;
            assign main_clr     = flush | (consume & ~take);
            assign main_ld_ctrl = in_ctrl;
            assign main_ld_data = in_data;
            assign occupancy    = {1'b0, out_valid};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: skid (16- and 4-bit counters) and single-register variants on shared stimulus.
module tb_pipe_stage_reg;
    import pcpu_pipe_pkg::*;

    localparam int DW = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst, flush, in_valid, out_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;

    logic          a_in_ready, a_out_valid, b_in_ready, b_out_valid, c_in_ready, c_out_valid;
    logic [CW-1:0] a_out_ctrl, b_out_ctrl, c_out_ctrl;
    logic [DW-1:0] a_out_data, b_out_data, c_out_data;
    logic [1:0]    a_occ, b_occ, c_occ;
    logic [15:0]   a_stall, b_stall;
    logic [3:0]    c_stall;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(16)) u_a (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_ctrl(a_out_ctrl), .out_data(a_out_data), .occupancy(a_occ), .stall_cnt(a_stall));

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CNT_W(16)) u_b (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_ctrl(b_out_ctrl), .out_data(b_out_data), .occupancy(b_occ), .stall_cnt(b_stall));

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(4)) u_c (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(c_in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(c_out_valid), .out_ready(out_ready),
        .out_ctrl(c_out_ctrl), .out_data(c_out_data), .occupancy(c_occ), .stall_cnt(c_stall));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_ctrl = '0; in_data = '0;

        // Reset cycle: everything zero, skid in_ready low
        tick();
        chk("rst_in_ready",  64'(a_in_ready),  64'd0);
        chk("rst_out_valid", 64'(a_out_valid), 64'd0);
        chk("rst_out_ctrl",  64'(a_out_ctrl),  64'd0);
        chk("rst_out_data",  64'(a_out_data),  64'd0);
        chk("rst_occ",       64'(a_occ),       64'd0);
        chk("rst_stall",     64'(a_stall),     64'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_in_ready", 64'(a_in_ready), 64'd1);
        chk("post_rst_ov",       64'(a_out_valid), 64'd0);

        // Single entry, then 10 back-to-back
        in_valid = 1'b1; in_data = 32'hA5; in_ctrl = 4'b0011; out_ready = 1'b1;
        tick();
        chk("first_ov",   64'(a_out_valid), 64'd1);
        chk("first_data", 64'(a_out_data),  64'hA5);
        chk("first_ctrl", 64'(a_out_ctrl),  64'h3);
        chk("first_occ",  64'(a_occ),       64'd1);
        for (int i = 1; i <= 10; i++) begin
            in_data = 32'(32'h100 + i);
            tick();
            chk("stream_ov",   64'(a_out_valid), 64'd1);
            chk("stream_data", 64'(a_out_data),  64'(32'h100 + i));
            chk("stream_rdy",  64'(a_in_ready),  64'd1);
        end
        in_valid = 1'b0;
        tick();
        chk("drain_ov",    64'(a_out_valid), 64'd0);
        chk("drain_occ",   64'(a_occ),       64'd0);
        chk("drain_stall", 64'(a_stall),     64'd0);

        // Bubble gating
        in_ctrl = 4'b1111;
        tick();
        chk("bubble_ov",   64'(a_out_valid), 64'd0);
        chk("bubble_ctrl", 64'(a_out_ctrl),  64'd0);
        tick();
        chk("bubble_ctrl2", 64'(a_out_ctrl), 64'd0);

        // Back-pressure fills skid
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'd1; in_ctrl = 4'b0001;
        tick();
        chk("bp1_data",  64'(a_out_data), 64'd1);
        chk("bp1_occ",   64'(a_occ),      64'd1);
        chk("bp1_stall", 64'(a_stall),    64'd0);
        in_data = 32'd2; in_ctrl = 4'b0010;
        tick();
        chk("bp2_occ",   64'(a_occ),       64'd2);
        chk("bp2_rdy",   64'(a_in_ready),  64'd0);
        chk("bp2_data",  64'(a_out_data),  64'd1);
        chk("bp2_stall", 64'(a_stall),     64'd1);
        in_valid = 1'b0;
        tick();
        chk("bp3_stall", 64'(a_stall), 64'd2);
        chk("bp3_occ",   64'(a_occ),   64'd2);
        out_ready = 1'b1;
        #1;
        chk("pop1_data", 64'(a_out_data), 64'd1);
        tick();
        chk("pop2_data",  64'(a_out_data),  64'd2);
        chk("pop2_ctrl",  64'(a_out_ctrl),  64'h2);
        chk("pop2_occ",   64'(a_occ),       64'd1);
        chk("pop2_rdy",   64'(a_in_ready),  64'd1);
        chk("pop2_stall", 64'(a_stall),     64'd2);
        tick();
        chk("pop3_ov",   64'(a_out_valid), 64'd0);
        chk("pop3_ctrl", 64'(a_out_ctrl),  64'd0);

        // Refill to two, then flush with a competing input
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h11; in_ctrl = 4'b0001;
        tick();
        in_data = 32'h22; in_ctrl = 4'b0010;
        tick();
        chk("refill_occ",   64'(a_occ),   64'd2);
        chk("refill_stall", 64'(a_stall), 64'd3);
        flush = 1'b1; in_data = 32'd3; in_ctrl = 4'b1111; a_flush_in_ready_check();
        tick();
        chk("flush_ov",    64'(a_out_valid), 64'd0);
        chk("flush_ctrl",  64'(a_out_ctrl),  64'd0);
        chk("flush_occ",   64'(a_occ),       64'd0);
        chk("flush_rdy",   64'(a_in_ready),  64'd1);
        chk("flush_data",  64'(a_out_data),  64'h11);
        chk("flush_stall", 64'(a_stall),     64'd4);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("post_flush_ov", 64'(a_out_valid), 64'd0);
            chk("post_flush_stall", 64'(a_stall), 64'd4);
        end

        // Counter saturation (4-bit instance) and reset mid-stall
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h55; in_ctrl = 4'b0011;
        tick();
        in_valid = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 10) chk("sat_c_mid", 64'(c_stall), 64'd14);
        end
        chk("sat_c_stall", 64'(c_stall), 64'd15);
        chk("sat_a_stall", 64'(a_stall), 64'd24);
        rst = 1'b1;
        tick();
        chk("mid_rst_a_ov",    64'(a_out_valid), 64'd0);
        chk("mid_rst_a_ctrl",  64'(a_out_ctrl),  64'd0);
        chk("mid_rst_a_data",  64'(a_out_data),  64'd0);
        chk("mid_rst_a_occ",   64'(a_occ),       64'd0);
        chk("mid_rst_a_stall", 64'(a_stall),     64'd0);
        chk("mid_rst_a_rdy",   64'(a_in_ready),  64'd0);
        chk("mid_rst_c_stall", 64'(c_stall),     64'd0);
        chk("mid_rst_c_data",  64'(c_out_data),  64'd0);
        rst = 1'b0;
        tick();
        chk("rerst_a_rdy", 64'(a_in_ready), 64'd1);

        // Single-register variant: combinational in_ready
        in_valid = 1'b1; in_data = 32'h77; in_ctrl = 4'b0001; out_ready = 1'b0;
        tick();
        chk("b_ov",   64'(b_out_valid), 64'd1);
        chk("b_rdy0", 64'(b_in_ready),  64'd0);
        in_data = 32'h88; in_ctrl = 4'b0010;
        tick();
        chk("b_hold_data", 64'(b_out_data), 64'h77);
        chk("b_stall",     64'(b_stall),    64'd1);
        out_ready = 1'b1;
        #1;
        chk("b_rdy1", 64'(b_in_ready), 64'd1);
        tick();
        chk("b_swap_data", 64'(b_out_data),  64'h88);
        chk("b_swap_ctrl", 64'(b_out_ctrl),  64'h2);
        chk("b_swap_occ",  64'(b_occ),       64'd1);
        in_valid = 1'b0;
        tick();
        chk("b_empty_ov",  64'(b_out_valid), 64'd0);
        chk("b_empty_occ", 64'(b_occ),       64'd0);
        chk("b_empty_rdy", 64'(b_in_ready),  64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // in_ready is still high at occupancy 2? No: the flush input must be dropped regardless.
    task automatic a_flush_in_ready_check();
        #1;
        chk("flush_cycle_rdy", 64'(a_in_ready), 64'd0);
    endtask

endmodule
